bin2rns_seq_4ch: RTL and testbench
==================================

// Module: bin2rns_seq_4ch
// PURPOSE
//  Sequential binary-to-RNS converter for a 4-modulus set {2^MOD_1_K, MOD_2, MOD_3, MOD_4}, parametrised in width and moduli.
//  Uses Horner folding, r = (r*2^B + chunk) mod m, over BITS_PER_CYCLE input bits per clock; no residue LUT inputs.
//  Valid/ready on both sides; sits between the binary operand source and the RNS channel datapaths.
// PARAMETERS
//  DYN_SIZE        16  input binary width; must be a multiple of BITS_PER_CYCLE
//  MOD_1_K          5  power-of-two modulus exponent (MOD_1 = 2^MOD_1_K)
//  MOD_2           17  odd modulus, >= 3
//  MOD_3           13  odd modulus, >= 3
//  MOD_4           11  odd modulus, >= 3
//  MAX_MOD          5  residue output width; >= MOD_1_K and >= clog2 of each odd modulus
//  BITS_PER_CYCLE   1  input bits folded per clock: 1, 2 or 4
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         synchronous, active-high
//  N          in   DYN_SIZE  unsigned binary operand
//  in_valid   in   1         N is valid
//  in_ready   out  1         converter can accept N
//  out_mod_1  out  MAX_MOD   N mod 2^MOD_1_K, zero-extended
//  out_mod_2  out  MAX_MOD   N mod MOD_2
//  out_mod_3  out  MAX_MOD   N mod MOD_3
//  out_mod_4  out  MAX_MOD   N mod MOD_4
//  range_err  out  1         N >= MOD_1*MOD_2*MOD_3*MOD_4 (outside the dynamic range); qualified by out_valid
//  out_valid  out  1         residues valid
//  out_ready  in   1         consumer accepts residues
//  busy       out  1         high in BUSY state
// BEHAVIOUR
//  Reset (sampled at clk edge with reset=1): state=IDLE; out_mod_1..4=0; range_err=0; out_valid=0; busy=0.
//   - Reset overrides any in-flight operation; the operand is discarded with no output.
//   - in_ready=1 in the cycle after the reset edge.
//  STEPS = DYN_SIZE/BITS_PER_CYCLE; step counter width clog2(STEPS+1).
//  FSM:
//   - IDLE: in_ready=1. On in_valid: capture N into a shift register.
//     - out_mod_1 <= N[MOD_1_K-1:0].
//     - range_err <= (N >= product); product is a localparam computed at elaboration.
//     - r2,r3,r4 <= 0; cnt <= 0; -> BUSY.
//   - BUSY: busy=1, in_ready=0. Each edge consumes the top BITS_PER_CYCLE bits of the shift register, MSB first.
//     - Per bit b, per channel: r = 2r+b; if r >= m, r = r-m. Invariant r < m holds after every bit.
//     - Intermediate width clog2(m)+1; no overflow.
//     - Shift register moves left by BITS_PER_CYCLE; cnt++.
//     - On the edge where cnt reaches STEPS: load out_mod_2..4 from r2..r4 -> DONE.
//   - DONE: out_valid=1; outputs held stable while out_ready=0. On out_ready:
//     - with in_valid: accept the new N exactly as IDLE does -> BUSY (back-to-back);
//     - otherwise -> IDLE, out_valid=0 next cycle.
//  in_ready = (state==IDLE) | (state==DONE & out_ready), combinational from state and out_ready.
//  Latency: accept at edge E0 gives out_valid=1 after edge E0+STEPS (16 clocks at defaults).
//  Throughput: one result per STEPS+1 clocks under continuous valid/ready.
//  Outputs change only on an accept edge (out_mod_1, range_err) or the final BUSY edge (out_mod_2..4).
//   - Consumers sample only under out_valid.
//  in_valid while not ready: ignored; N is not latched; no error.
//  N=0: all residues 0. range_err=1 still yields correct true residues of N.
//  Unused upper bits of each out_mod_x are driven 0.
// TESTING
//  1. Reset for 2 cycles, then idle -> all residue outputs 0, out_valid=0, busy=0, in_ready=1.
//  2. Defaults, N=1000 -> after 16 clocks: out_valid=1, residues (8,14,12,10), range_err=0.
//  3. Defaults, N=65535 -> residues (31,0,2,8), range_err=0.
//  4. N=1000, hold out_ready=0 for 5 cycles, then out_ready=1 with in_valid=1, N=65535:
//     - residues stable and in_ready=0 while held;
//     - second operand accepted on the release edge;
//     - (31,0,2,8) valid 16 clocks later.
//  5. reset=1 at the 7th BUSY cycle of N=1000 -> out_valid never rises; IDLE next cycle; next N=1000 gives (8,14,12,10).
//  6. DYN_SIZE=17, BITS_PER_CYCLE=4 (STEPS=5 via 20-bit pad), N=77792:
//     - range_err=1, residues (0,0,0,0), out_valid after 5 clocks;
//     - N=1000 -> (8,14,12,10), range_err=0.

Source files
------------

// File: rtl/bin2rns_seq_4ch.sv
// Sequential binary-to-RNS converter for {2^MOD_1_K, MOD_2, MOD_3, MOD_4}.
// Horner folding of BITS_PER_CYCLE operand bits per clock, MSB first.
module bin2rns_seq_4ch #(
  parameter int unsigned DYN_SIZE       = 16,
  parameter int unsigned MOD_1_K        = 5,
  parameter int unsigned MOD_2          = 17,
  parameter int unsigned MOD_3          = 13,
  parameter int unsigned MOD_4          = 11,
  parameter int unsigned MAX_MOD        = 5,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DYN_SIZE-1:0] N,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [MAX_MOD-1:0]  out_mod_1,
  output logic [MAX_MOD-1:0]  out_mod_2,
  output logic [MAX_MOD-1:0]  out_mod_3,
  output logic [MAX_MOD-1:0]  out_mod_4,
  output logic                range_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int unsigned STEPS = (DYN_SIZE + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int unsigned PAD_W = STEPS * BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam int unsigned RW    = MAX_MOD + 1;

  localparam logic [63:0] PRODUCT = (64'd1 << MOD_1_K) * 64'(MOD_2) * 64'(MOD_3) * 64'(MOD_4);

  localparam logic [RW-1:0] M2 = RW'(MOD_2);
  localparam logic [RW-1:0] M3 = RW'(MOD_3);
  localparam logic [RW-1:0] M4 = RW'(MOD_4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PAD_W-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic [MAX_MOD-1:0] r_r2, r_r3, r_r4;
  logic [MAX_MOD-1:0] r_mod_1, r_mod_2, r_mod_3, r_mod_4;
  logic               r_range_err;

  logic                      w_accept;
  logic                      w_last;
  logic [BITS_PER_CYCLE-1:0] w_chunk;
  logic [MAX_MOD-1:0]        w_r2_nxt, w_r3_nxt, w_r4_nxt;

  // One Horner step per bit: r = 2r + b, then a single conditional subtract
  // keeps r < m, so RW = MAX_MOD+1 bits never overflow.
  function automatic logic [MAX_MOD-1:0] fold(input logic [MAX_MOD-1:0]        r_in,
                                              input logic [BITS_PER_CYCLE-1:0] chunk,
                                              input logic [RW-1:0]             m);
    logic [RW-1:0]             r;
    logic [BITS_PER_CYCLE-1:0] c;
    r = {1'b0, r_in};
    c = chunk;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      r = {r[RW-2:0], c[BITS_PER_CYCLE-1]};
      if (r >= m) r = r - m;
      c = c << 1;
    end
    return r[MAX_MOD-1:0];
  endfunction

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_cnt == CNT_W'(STEPS - 1));
  assign w_chunk   = r_shreg[PAD_W-1 -: BITS_PER_CYCLE];
  assign w_r2_nxt  = fold(r_r2, w_chunk, M2);
  assign w_r3_nxt  = fold(r_r3, w_chunk, M3);
  assign w_r4_nxt  = fold(r_r4, w_chunk, M4);

  assign out_mod_1 = r_mod_1;
  assign out_mod_2 = r_mod_2;
  assign out_mod_3 = r_mod_3;
  assign out_mod_4 = r_mod_4;
  assign range_err = r_range_err;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = BUSY;
      BUSY:    if (w_last)   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = in_valid ? BUSY : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_r2        <= '0;
      r_r3        <= '0;
      r_r4        <= '0;
      r_mod_1     <= '0;
      r_mod_2     <= '0;
      r_mod_3     <= '0;
      r_mod_4     <= '0;
      r_range_err <= 1'b0;
    end else if (w_accept) begin
      // Operand is zero-padded at the top so STEPS*BITS_PER_CYCLE bits fold cleanly.
      r_shreg     <= PAD_W'(N);
      r_cnt       <= '0;
      r_r2        <= '0;
      r_r3        <= '0;
      r_r4        <= '0;
      r_mod_1     <= MAX_MOD'(N[MOD_1_K-1:0]);
      r_range_err <= (64'(N) >= PRODUCT);
    end else if (r_state == BUSY) begin
      r_shreg <= r_shreg << BITS_PER_CYCLE;
      r_cnt   <= r_cnt + 1'b1;
      r_r2    <= w_r2_nxt;
      r_r3    <= w_r3_nxt;
      r_r4    <= w_r4_nxt;
      if (w_last) begin
        r_mod_2 <= w_r2_nxt;
        r_mod_3 <= w_r3_nxt;
        r_mod_4 <= w_r4_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bin2rns_seq_4ch.sv
// Scoreboard bench for bin2rns_seq_4ch: default config and a 17-bit, 4-bit/cycle config
// run side by side against a plain modulo-arithmetic reference with a cycle-accurate timing model.
module tb_bin2rns_seq_4ch;

  typedef struct {
    logic [4:0]  m1, m2, m3, m4;
    logic        err;
    int unsigned vcyc;
  } exp_t;

  localparam longint unsigned PROD = 64'd32 * 64'd17 * 64'd13 * 64'd11;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc   = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input int ch, input string nm,
                              input longint unsigned act, input longint unsigned req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL ch%0d %s: got %0d, expected %0d (cycle %0d)", ch, nm, act, req, cyc);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int unsigned DW    = (g == 0) ? 16 : 17;
    localparam int unsigned BPC   = (g == 0) ? 1 : 4;
    localparam int unsigned STEPS = (DW + BPC - 1) / BPC;

    logic [DW-1:0] N         = '0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, range_err, busy;
    logic [4:0]    m1, m2, m3, m4;

    exp_t        q[$];
    bit          post_rst = 1'b1;
    bit          done     = 1'b0;
    int unsigned qn       = 0;

    bin2rns_seq_4ch #(
      .DYN_SIZE      (DW),
      .MOD_1_K       (5),
      .MOD_2         (17),
      .MOD_3         (13),
      .MOD_4         (11),
      .MAX_MOD       (5),
      .BITS_PER_CYCLE(BPC)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .N        (N),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_mod_1(m1),
      .out_mod_2(m2),
      .out_mod_3(m3),
      .out_mod_4(m4),
      .range_err(range_err),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy)
    );

    // Accepted before edge c+1; result visible after STEPS further edges.
    function automatic exp_t model(input logic [DW-1:0] v, input int unsigned c);
      exp_t            e;
      longint unsigned x;
      x      = 64'(v);
      e.m1   = 5'(x % 32);
      e.m2   = 5'(x % 17);
      e.m3   = 5'(x % 13);
      e.m4   = 5'(x % 11);
      e.err  = (x >= PROD);
      e.vcyc = c + 1 + STEPS;
      return e;
    endfunction

    task automatic send(input logic [DW-1:0] v, input bit scramble);
      int unsigned t;
      t        = 0;
      N        = v;
      in_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (reset || in_ready) break;
        t++;
        if (t > 400) begin
          chk(g, "accept_timeout", 0, 1);
          break;
        end
        @(posedge clk);
        #1;
        if (scramble) N = DW'($urandom);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    endtask

    initial begin : drv
      int unsigned gap;
      wait (!reset);
      send(DW'(1000), 1'b0);
      send(DW'(65535), 1'b0);
      send('0, 1'b0);
      send('1, 1'b0);
      if (g == 1) begin
        send(DW'(77792), 1'b0);
        send(DW'(77791), 1'b0);
      end
      for (int i = 0; i < 60; i++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        send(DW'($urandom), 1'b1);
      end
      done = 1'b1;
    end

    initial begin : rdy
      int unsigned hold;
      hold = 0;
      forever begin
        @(posedge clk);
        #1;
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else if ($urandom_range(0, 3) == 0) begin
          hold      = $urandom_range(0, 5);
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
        end
      end
    end

    always @(negedge clk) begin : mon
      bit   ev, eb, er;
      exp_t e;
      if (reset) begin
        q.delete();
        post_rst = 1'b1;
      end else begin
        ev = (q.size() > 0) && (cyc >= q[0].vcyc);
        eb = (q.size() > 0) && !ev;
        er = ev ? out_ready : !eb;
        chk(g, "out_valid", out_valid, ev);
        chk(g, "busy", busy, eb);
        chk(g, "in_ready", in_ready, er);
        if (ev) begin
          e = q[0];
          chk(g, "out_mod_1", m1, e.m1);
          chk(g, "out_mod_2", m2, e.m2);
          chk(g, "out_mod_3", m3, e.m3);
          chk(g, "out_mod_4", m4, e.m4);
          chk(g, "range_err", range_err, e.err);
        end else if (post_rst && q.size() == 0) begin
          chk(g, "rst_mod_1", m1, 0);
          chk(g, "rst_mod_2", m2, 0);
          chk(g, "rst_mod_3", m3, 0);
          chk(g, "rst_mod_4", m4, 0);
          chk(g, "rst_range_err", range_err, 0);
        end
        if (ev && out_ready) void'(q.pop_front());
        if (in_valid && er) begin
          q.push_back(model(N, cyc));
          post_rst = 1'b0;
        end
      end
      qn = q.size();
    end
  end

  initial begin : main
    int unsigned t;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (200) @(posedge clk);
    // Resets landing mid-conversion: the in-flight operand must vanish without output.
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!ch[0].busy && t < 500) begin
        @(negedge clk);
        t++;
      end
      repeat (6) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat ($urandom_range(40, 160)) @(posedge clk);
    end
    t = 0;
    while (!(ch[0].done && ch[1].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (!(ch[0].done && ch[1].done)) chk(0, "stimulus_timeout", 0, 1);
    t = 0;
    while ((ch[0].qn != 0 || ch[1].qn != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk(0, "drain_pending", ch[0].qn + ch[1].qn, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
